// File: rtl/ac97_pkg.sv
// Shared AC97 frame feeder types: slot/address widths, FSM state, slot1 builder.
// Optional feature macro (see ac97_pcm_buffer): AC97_UNDERRUN_CNT_EN.
package ac97_pkg;

    localparam int SLOT_W = 20;
    localparam int ADDR_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

    // Command address slot: bit 19 is the read flag, address in 18:12.
    function automatic logic [SLOT_W-1:0] build_slot1(
        input logic              write,
        input logic [ADDR_W-1:0] addr
    );
        return {~write, addr, 12'h000};
    endfunction

endpackage

// File: rtl/ac97_pcm_buffer.sv
// One-entry stereo PCM buffer feeding slots 3/4 on each frame strobe.
// Define AC97_UNDERRUN_CNT_EN to count underrun frames (saturating).
module ac97_pcm_buffer
    import ac97_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    input  logic [SLOT_W-1:0] pcm_left,
    input  logic [SLOT_W-1:0] pcm_right,
    output logic [SLOT_W-1:0] slot3,
    output logic [SLOT_W-1:0] slot4,
    output logic              slot3_valid,
    output logic              slot4_valid,
    output logic [15:0]       underruns
);

    logic              full;
    logic [SLOT_W-1:0] buf_left;
    logic [SLOT_W-1:0] buf_right;
    logic              accept;

    assign pcm_ready = ~full;
    assign accept    = pcm_valid & ~full;

    // Buffer fill/drain; an accept on a strobe cycle waits for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full        <= 1'b0;
            buf_left    <= '0;
            buf_right   <= '0;
            slot3       <= '0;
            slot4       <= '0;
            slot3_valid <= 1'b0;
            slot4_valid <= 1'b0;
        end else begin
            if (strobe) begin
                if (full) begin
                    slot3       <= buf_left;
                    slot4       <= buf_right;
                    slot3_valid <= 1'b1;
                    slot4_valid <= 1'b1;
                end else begin
                    slot3       <= '0;
                    slot4       <= '0;
                    slot3_valid <= 1'b0;
                    slot4_valid <= 1'b0;
                end
            end
            if (accept) begin
                buf_left  <= pcm_left;
                buf_right <= pcm_right;
                full      <= 1'b1;
            end else if (strobe && full) begin
                full <= 1'b0;
            end
        end
    end

`ifdef AC97_UNDERRUN_CNT_EN
    logic [15:0] under_cnt;

    // Count frames that went out with no sample, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            under_cnt <= '0;
        end else if (strobe && !full && under_cnt != 16'hFFFF) begin
            under_cnt <= under_cnt + 16'd1;
        end
    end

    assign underruns = under_cnt;
`else
    assign underruns = '0;
`endif

endmodule

// File: rtl/ac97_frame_feeder.sv
// AC97 frame feeder: codec register commands on slots 1/2, PCM on slots 3/4.
// Optional underrun counter enabled by AC97_UNDERRUN_CNT_EN.
module ac97_frame_feeder
    import ac97_pkg::*;
#(
    parameter int RSP_TIMEOUT_FRAMES = 4
) (
    input  logic              ac97_bitclk,
    input  logic              ac97_rst,
    input  logic              ac97_strobe,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [15:0]       cmd_wdata,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [15:0]       rsp_data,
    output logic              rsp_timeout,
    input  logic [15:0]       in_tag,
    input  logic [SLOT_W-1:0] in_slot1,
    input  logic [SLOT_W-1:0] in_slot2,
    input  logic              pcm_valid,
    output logic              pcm_ready,
    input  logic [SLOT_W-1:0] pcm_left,
    input  logic [SLOT_W-1:0] pcm_right,
    output logic [SLOT_W-1:0] out_slot1,
    output logic [SLOT_W-1:0] out_slot2,
    output logic [SLOT_W-1:0] out_slot3,
    output logic [SLOT_W-1:0] out_slot4,
    output logic              out_slot1_valid,
    output logic              out_slot2_valid,
    output logic              out_slot3_valid,
    output logic              out_slot4_valid,
    output logic              busy,
    output logic [15:0]       pcm_underruns
);

    localparam logic [3:0] TMO = 4'(RSP_TIMEOUT_FRAMES);

    state_e            state;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [15:0]       lat_wdata;
    logic [3:0]        frame_cnt;
    logic [3:0]        frame_cnt_nxt;
    logic              match;
    logic              unused_bits;

    assign cmd_ready     = (state == ST_IDLE) & ~ac97_rst;
    assign busy          = (state == ST_ISSUE) | (state == ST_WAIT_RSP);
    assign frame_cnt_nxt = frame_cnt + 4'd1;
    assign match         = in_tag[14] & (in_slot1[18:12] == lat_addr);
    assign unused_bits   = ^{in_tag[15], in_tag[13:0], in_slot1[19],
                             in_slot1[11:0], in_slot2[3:0]};

    // Command slots change only on strobes: one frame of command, then zeros.
    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) begin
            out_slot1       <= '0;
            out_slot2       <= '0;
            out_slot1_valid <= 1'b0;
            out_slot2_valid <= 1'b0;
        end else if (ac97_strobe) begin
            if (state == ST_ISSUE) begin
                out_slot1       <= build_slot1(lat_write, lat_addr);
                out_slot1_valid <= 1'b1;
                out_slot2       <= lat_write ? {lat_wdata, 4'h0} : '0;
                out_slot2_valid <= lat_write;
            end else begin
                out_slot1       <= '0;
                out_slot2       <= '0;
                out_slot1_valid <= 1'b0;
                out_slot2_valid <= 1'b0;
            end
        end
    end

    // Command FSM with response matching and frame-count timeout.
    always_ff @(posedge ac97_bitclk or posedge ac97_rst) begin
        if (ac97_rst) begin
            state       <= ST_IDLE;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            frame_cnt   <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lat_write <= cmd_write;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ac97_strobe) begin
                        frame_cnt <= '0;
                        state     <= lat_write ? ST_IDLE : ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (ac97_strobe) begin
                        if (match) begin
                            rsp_valid   <= 1'b1;
                            rsp_addr    <= lat_addr;
                            rsp_data    <= in_slot2[19:4];
                            rsp_timeout <= 1'b0;
                            state       <= ST_IDLE;
                        end else if (frame_cnt_nxt == TMO) begin
                            rsp_valid   <= 1'b1;
                            rsp_addr    <= lat_addr;
                            rsp_data    <= '0;
                            rsp_timeout <= 1'b1;
                            state       <= ST_IDLE;
                        end else begin
                            frame_cnt <= frame_cnt_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ac97_pcm_buffer u_pcm (
        .clk         (ac97_bitclk),
        .rst         (ac97_rst),
        .strobe      (ac97_strobe),
        .pcm_valid   (pcm_valid),
        .pcm_ready   (pcm_ready),
        .pcm_left    (pcm_left),
        .pcm_right   (pcm_right),
        .slot3       (out_slot3),
        .slot4       (out_slot4),
        .slot3_valid (out_slot3_valid),
        .slot4_valid (out_slot4_valid),
        .underruns   (pcm_underruns)
    );

endmodule

// File: tb/tb_ac97_frame_feeder.sv
// Self-checking bench for ac97_frame_feeder: command vector table,
// response scoreboard, PCM and reset corner sequences.
module tb_ac97_frame_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [6:0]  rsp_addr;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [15:0] in_tag;
    logic [19:0] in_slot1;
    logic [19:0] in_slot2;
    logic        pcm_valid;
    logic        pcm_ready;
    logic [19:0] pcm_left;
    logic [19:0] pcm_right;
    logic [19:0] s1, s2, s3, s4;
    logic        v1, v2, v3, v4;
    logic        busy;
    logic [15:0] underruns;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
        logic        tmo;
    } rsp_t;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [15:0] wdata;
        logic [19:0] s1;
        logic [19:0] s2;
        logic        v2;
    } vec_t;

    rsp_t exp_q[$];
    rsp_t got_q[$];
    int   rd_idx = 0;
    int   checks = 0;
    int   passes = 0;
    vec_t vecs[4];
    logic [15:0] exp_under;

    always #5 clk = ~clk;

    ac97_frame_feeder #(.RSP_TIMEOUT_FRAMES(4)) dut (
        .ac97_bitclk     (clk),
        .ac97_rst        (rst),
        .ac97_strobe     (strobe),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_addr        (cmd_addr),
        .cmd_wdata       (cmd_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_addr        (rsp_addr),
        .rsp_data        (rsp_data),
        .rsp_timeout     (rsp_timeout),
        .in_tag          (in_tag),
        .in_slot1        (in_slot1),
        .in_slot2        (in_slot2),
        .pcm_valid       (pcm_valid),
        .pcm_ready       (pcm_ready),
        .pcm_left        (pcm_left),
        .pcm_right       (pcm_right),
        .out_slot1       (s1),
        .out_slot2       (s2),
        .out_slot3       (s3),
        .out_slot4       (s4),
        .out_slot1_valid (v1),
        .out_slot2_valid (v2),
        .out_slot3_valid (v3),
        .out_slot4_valid (v4),
        .busy            (busy),
        .pcm_underruns   (underruns)
    );

    // Response monitor: every rsp_valid cycle is captured in order.
    always @(negedge clk) begin
        if (rsp_valid) got_q.push_back('{rsp_addr, rsp_data, rsp_timeout});
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%h exp=%h", name, got, exp);
    endtask

    task automatic frame(input int gap);
        repeat (gap) @(negedge clk);
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
    endtask

    task automatic send_cmd(input logic wr, input logic [6:0] a,
                            input logic [15:0] d);
        int n;
        n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic set_in(input logic [15:0] t, input logic [6:0] a,
                          input logic [19:0] d);
        in_tag   = t;
        in_slot1 = {1'b0, a, 12'h000};
        in_slot2 = d;
    endtask

    task automatic check_rsp();
        rsp_t e;
        rsp_t g;
        for (int i = 0; i < 8 && got_q.size() <= rd_idx; i++)
            @(negedge clk);
        e = exp_q.pop_front();
        if (got_q.size() > rd_idx) begin
            g = got_q[rd_idx];
            rd_idx++;
            check("rsp_addr", 32'(g.addr), 32'(e.addr));
            check("rsp_data", 32'(g.data), 32'(e.data));
            check("rsp_timeout", 32'(g.tmo), 32'(e.tmo));
        end else begin
            check("rsp_arrived", 32'd0, 32'd1);
        end
    endtask

    task automatic check_no_rsp(input string name);
        check(name, 32'(got_q.size()), 32'(rd_idx));
    endtask

    initial begin
        vecs[0] = '{1'b1, 7'h02, 16'h8000, 20'h02000, 20'h80000, 1'b1};
        vecs[1] = '{1'b1, 7'h7F, 16'hFFFF, 20'h7F000, 20'hFFFF0, 1'b1};
        vecs[2] = '{1'b1, 7'h00, 16'h1234, 20'h00000, 20'h12340, 1'b1};
        vecs[3] = '{1'b0, 7'h3A, 16'hAAAA, 20'hBA000, 20'h00000, 1'b0};

        rst = 1'b1; strobe = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; pcm_valid = 1'b0;
        pcm_left = '0; pcm_right = '0;
        set_in(16'h0, 7'h0, 20'h0);
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_slot1", 32'({v1, s1}), 32'd0);
        check("reset_rsp", 32'({rsp_valid, rsp_addr, rsp_data}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pcm_ready", 32'(pcm_ready), 32'd1);
        check("idle_underruns", 32'(underruns), 32'd0);

        // PCM: accept, transmit, then underrun frame.
        exp_under = '0;
        @(negedge clk);
        pcm_valid = 1'b1; pcm_left = 20'h12345; pcm_right = 20'h54321;
        @(negedge clk);
        pcm_valid = 1'b0;
        check("pcm_full_ready", 32'(pcm_ready), 32'd0);
        frame(2);
        check("pcm_slot3", 32'(s3), 32'h12345);
        check("pcm_slot4", 32'(s4), 32'h54321);
        check("pcm_valids", 32'({v3, v4}), 32'd3);
        check("pcm_ready_after", 32'(pcm_ready), 32'd1);
        frame(2);
`ifdef AC97_UNDERRUN_CNT_EN
        exp_under = exp_under + 16'd1;
`endif
        check("under_valids", 32'({v3, v4}), 32'd0);
        check("under_slot3", 32'(s3), 32'd0);
        check("under_count", 32'(underruns), 32'(exp_under));

        // Accept on the strobe cycle is held for the following frame.
        @(negedge clk);
        pcm_valid = 1'b1; pcm_left = 20'hABCDE; pcm_right = 20'h0F0F0;
        strobe = 1'b1;
        @(negedge clk);
        pcm_valid = 1'b0; strobe = 1'b0;
`ifdef AC97_UNDERRUN_CNT_EN
        exp_under = exp_under + 16'd1;
`endif
        check("same_strobe_v3", 32'(v3), 32'd0);
        check("same_strobe_full", 32'(pcm_ready), 32'd0);
        check("same_strobe_cnt", 32'(underruns), 32'(exp_under));
        frame(1);
        check("held_slot3", 32'(s3), 32'hABCDE);
        check("held_slot4", 32'(s4), 32'h0F0F0);

        // Command vector table.
        for (int i = 0; i < 4; i++) begin
            send_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            check("vec_busy", 32'(busy), 32'd1);
            check("vec_pre_v1", 32'(v1), 32'd0);
            if (!vecs[i].wr) exp_q.push_back('{vecs[i].addr, 16'h0, 1'b1});
            frame(2);
            check("vec_slot1", 32'(s1), 32'(vecs[i].s1));
            check("vec_v1", 32'(v1), 32'd1);
            check("vec_slot2", 32'(s2), 32'(vecs[i].s2));
            check("vec_v2", 32'(v2), 32'(vecs[i].v2));
            frame(2);
            check("vec_clear", 32'({v1, v2, s1 | s2}), 32'd0);
            if (!vecs[i].wr) begin
                repeat (2) frame(1);
                check_no_rsp("vec_early_rsp");
                frame(1);
                check_rsp();
            end else begin
                check("vec_wr_idle", 32'(busy), 32'd0);
                check_no_rsp("vec_wr_rsp");
            end
        end

        // Read 7C answered on the second waiting frame.
        send_cmd(1'b0, 7'h7C, 16'h0);
        exp_q.push_back('{7'h7C, 16'h4144, 1'b0});
        frame(2);
        check("rd7c_slot1", 32'(s1), 32'hFC000);
        frame(2);
        check("rd7c_busy", 32'(busy), 32'd1);
        set_in(16'h4000, 7'h7C, 20'h41440);
        repeat (3) @(negedge clk);
        check_no_rsp("rd7c_nonstrobe");
        frame(0);
        set_in(16'h0, 7'h0, 20'h0);
        check_rsp();
        check("rd7c_hold_data", 32'(rsp_data), 32'h4144);

        // Tag bit clear: address alone is not a match.
        send_cmd(1'b0, 7'h10, 16'h0);
        exp_q.push_back('{7'h10, 16'h0, 1'b1});
        frame(1);
        set_in(16'h0000, 7'h10, 20'h11110);
        repeat (4) frame(1);
        set_in(16'h0, 7'h0, 20'h0);
        check_rsp();

        // Read 26 with replies for another address times out.
        send_cmd(1'b0, 7'h26, 16'h0);
        exp_q.push_back('{7'h26, 16'h0, 1'b1});
        frame(1);
        set_in(16'h4000, 7'h25, 20'h99990);
        repeat (3) frame(1);
        check_no_rsp("rd26_early");
        frame(1);
        set_in(16'h0, 7'h0, 20'h0);
        check_rsp();
        check("rd26_idle", 32'(cmd_ready), 32'd1);

        // Match on the timeout frame wins.
        send_cmd(1'b0, 7'h11, 16'h0);
        exp_q.push_back('{7'h11, 16'hBEEF, 1'b0});
        frame(1);
        repeat (3) frame(1);
        set_in(16'h4000, 7'h11, 20'hBEEF0);
        frame(1);
        set_in(16'h0, 7'h0, 20'h0);
        check_rsp();

        // Reset while waiting for a response aborts silently.
        pcm_valid = 1'b1; pcm_left = 20'h77777; pcm_right = 20'h88888;
        @(negedge clk);
        pcm_valid = 1'b0;
        send_cmd(1'b0, 7'h26, 16'h0);
        frame(1);
        check("rst_pre_slot1", 32'(s1), 32'hA6000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready_rel", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_slots", 32'(s1 | s2 | s3 | s4), 32'd0);
        check("rst_valids", 32'({v1, v2, v3, v4}), 32'd0);
        check("rst_underruns", 32'(underruns), 32'd0);
        check("rst_pcm_ready", 32'(pcm_ready), 32'd1);
        repeat (5) frame(1);
        check_no_rsp("rst_no_rsp");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
